// File: rtl/quant_drain_perchan.sv
// quant_drain_perchan
// Snapshots a ROWS x COLS accumulator tile, then quantizes it per column
// (scale, rounding right shift, zero point, saturation) and streams it out
// as GROUP_ROWS-row beats.
// Optional build macro: QUANT_RELU_EN adds a relu_en input that clamps
// results below zero_point up to zero_point.
//
// Output handshake: a beat transfers on a rising clk edge where
// out_valid && out_ready. Once out_valid is high, out_data and out_row hold
// until that transfer. out_valid never drops without a transfer, except on reset.
module quant_drain_perchan #(
  parameter int ROWS        = 32,
  parameter int COLS        = 16,
  parameter int ACC_WIDTH   = 32,
  parameter int OUT_WIDTH   = 8,
  parameter int SCALE_WIDTH = 16,
  parameter int SHIFT_WIDTH = 6,
  parameter int GROUP_ROWS  = 4
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          start,
  input  logic [ROWS-1:0][COLS-1:0][ACC_WIDTH-1:0]      acc_in,
  input  logic [COLS-1:0][SCALE_WIDTH-1:0]              scale,
  input  logic [COLS-1:0][SHIFT_WIDTH-1:0]              shift,
  input  logic [OUT_WIDTH-1:0]                          zero_point,
`ifdef QUANT_RELU_EN
  input  logic                                          relu_en,
`endif
  output logic [GROUP_ROWS-1:0][COLS-1:0][OUT_WIDTH-1:0] out_data,
  output logic [$clog2(ROWS)-1:0]                       out_row,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic                                          busy,
  output logic                                          done,
  output logic [15:0]                                   sat_count
);

  localparam int BEATS     = ROWS / GROUP_ROWS;
  localparam int BW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RW        = $clog2(ROWS);
  localparam int EW        = ACC_WIDTH + SCALE_WIDTH + 2;
  localparam int MAX_SHIFT = ACC_WIDTH + SCALE_WIDTH;
  localparam int SCW       = $clog2(GROUP_ROWS * COLS + 1);

  localparam logic signed [EW-1:0] OMAX = EW'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [EW-1:0] OMIN = EW'(-(1 << (OUT_WIDTH - 1)));

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [OUT_WIDTH-1:0] val;
    logic                 sat;
  } qres_t;

  state_t                                        state_q;
  logic [BW-1:0]                                 beat_q;
  logic [GROUP_ROWS-1:0][COLS-1:0][OUT_WIDTH-1:0] out_data_q;
  logic [RW-1:0]                                 out_row_q;
  logic                                          out_valid_q;
  logic                                          busy_q;
  logic                                          done_q;
  logic [15:0]                                   sat_q;

  // Snapshot of the tile and its quantization parameters (not reset).
  logic [ROWS-1:0][COLS-1:0][ACC_WIDTH-1:0]      snap_acc_q;
  logic [COLS-1:0][SCALE_WIDTH-1:0]              snap_scale_q;
  logic [COLS-1:0][SHIFT_WIDTH-1:0]              snap_shift_q;
  logic [OUT_WIDTH-1:0]                          snap_zp_q;
`ifdef QUANT_RELU_EN
  logic                                          snap_relu_q;
`endif

  logic [GROUP_ROWS-1:0][COLS-1:0][OUT_WIDTH-1:0] beat_data;
  logic [SCW-1:0]                                beat_sat;
  logic [RW-1:0]                                 row_base;
  logic [15:0]                                   sat_d;

  // Quantize one element: signed acc times unsigned scale, round half up,
  // arithmetic shift, add zero point, saturate to OUT_WIDTH.
  function automatic qres_t quantize(
    input logic [ACC_WIDTH-1:0]   acc,
    input logic [SCALE_WIDTH-1:0] sc,
    input logic [SHIFT_WIDTH-1:0] sh,
    input logic [OUT_WIDTH-1:0]   zp
  );
    logic signed [EW-1:0] p;
    logic signed [EW-1:0] rnd;
    logic signed [EW-1:0] r;
    logic signed [EW-1:0] q;
    int                   s;
    qres_t                res;
    s = int'(sh);
    if (s > MAX_SHIFT) s = MAX_SHIFT;
    p   = EW'($signed(acc)) * EW'($signed({1'b0, sc}));
    rnd = '0;
    if (s != 0) rnd = EW'(1) << (s - 1);
    r   = (p + rnd) >>> s;
    q   = r + EW'($signed(zp));
    res.sat = 1'b0;
    if (q > OMAX) begin
      res.val = OMAX[OUT_WIDTH-1:0];
      res.sat = 1'b1;
    end else if (q < OMIN) begin
      res.val = OMIN[OUT_WIDTH-1:0];
      res.sat = 1'b1;
    end else begin
      res.val = q[OUT_WIDTH-1:0];
    end
    return res;
  endfunction

  // Quantize the rows of the current beat and count saturated elements.
  always_comb begin
    qres_t         res;
    logic [RW-1:0] row_idx;
    logic [16:0]   sat_sum;
    beat_data = '0;
    beat_sat  = '0;
    res       = '0;
    row_base  = RW'(int'(beat_q) * GROUP_ROWS);
    row_idx   = row_base;
    for (int g = 0; g < GROUP_ROWS; g++) begin
      row_idx = row_base + RW'(g);
      for (int c = 0; c < COLS; c++) begin
        res = quantize(snap_acc_q[row_idx][c], snap_scale_q[c], snap_shift_q[c], snap_zp_q);
`ifdef QUANT_RELU_EN
        if (snap_relu_q && ($signed(res.val) < $signed(snap_zp_q))) res.val = snap_zp_q;
`endif
        beat_data[g][c] = res.val;
        beat_sat        = beat_sat + SCW'(res.sat);
      end
    end
    sat_sum = {1'b0, sat_q} + 17'(beat_sat);
    sat_d   = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end

  // Capture the tile and parameters when a drain is accepted.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && start) begin
      snap_acc_q   <= acc_in;
      snap_scale_q <= scale;
      snap_shift_q <= shift;
      snap_zp_q    <= zero_point;
`ifdef QUANT_RELU_EN
      snap_relu_q  <= relu_en;
`endif
    end
  end

  // Drain FSM with registered stream outputs and status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sat_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sat_q   <= '0;
            beat_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!out_valid_q || out_ready) begin
            out_data_q  <= beat_data;
            out_row_q   <= row_base;
            out_valid_q <= 1'b1;
            sat_q       <= sat_d;
            if (beat_q == BW'(BEATS - 1)) begin
              beat_q  <= '0;
              state_q <= ST_FLUSH;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sat_count = sat_q;

endmodule

// File: tb/tb_quant_drain_perchan.sv
// Testbench for quant_drain_perchan: random and directed tiles checked
// against an integer reference model, with a beat scoreboard.
module tb_quant_drain_perchan;

  localparam int ROWS  = 32;
  localparam int COLS  = 16;
  localparam int AW    = 32;
  localparam int OW    = 8;
  localparam int SW    = 16;
  localparam int HW    = 6;
  localparam int G     = 4;
  localparam int BEATS = ROWS / G;
  localparam int DW    = G * COLS * OW;
  localparam int RW    = $clog2(ROWS);
  localparam longint OMAX = (longint'(1) << (OW - 1)) - 1;
  localparam longint OMIN = -(longint'(1) << (OW - 1));

  logic                            clk;
  logic                            reset;
  logic                            start;
  logic [ROWS-1:0][COLS-1:0][AW-1:0] acc_in;
  logic [COLS-1:0][SW-1:0]         scale;
  logic [COLS-1:0][HW-1:0]         shift;
  logic [OW-1:0]                   zero_point;
`ifdef QUANT_RELU_EN
  logic                            relu_en;
`endif
  logic [G-1:0][COLS-1:0][OW-1:0]  out_data;
  logic [RW-1:0]                   out_row;
  logic                            out_valid;
  logic                            out_ready;
  logic                            busy;
  logic                            done;
  logic [15:0]                     sat_count;

  quant_drain_perchan dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .acc_in     (acc_in),
    .scale      (scale),
    .shift      (shift),
    .zero_point (zero_point),
`ifdef QUANT_RELU_EN
    .relu_en    (relu_en),
`endif
    .out_data   (out_data),
    .out_row    (out_row),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .sat_count  (sat_count)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- tile model state ----------------
  int  t_acc[ROWS][COLS];
  int  t_scale[COLS];
  int  t_shift[COLS];
  int  t_zp;
  bit  t_relu;
  int  exp_sat;

  logic [DW-1:0] exp_q[$];
  logic [RW-1:0] row_q[$];

  int  n_checks;
  int  n_bad;
  int  hs_count;
  bit  done_seen;
  int  ready_mode;
  logic [OW-1:0] first_elem;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] z8(input int v);
    logic [OW-1:0] t;
    t = OW'(v);
    return DW'(t);
  endfunction

  // Reference quantizer written from the arithmetic rules with 64-bit integers.
  function automatic longint ref_elem(input int acc, input int sc, input int sh,
                                      input int zp, input bit relu, output bit sat);
    longint p, r, q;
    int s;
    p = longint'(acc) * longint'(sc);
    s = (sh > AW + SW) ? AW + SW : sh;
    if (s > 0) r = (p + (longint'(1) << (s - 1))) >>> s;
    else       r = p;
    q = r + longint'(zp);
    sat = 1'b0;
    if (q > OMAX) begin q = OMAX; sat = 1'b1; end
    else if (q < OMIN) begin q = OMIN; sat = 1'b1; end
    if (relu && q < longint'(zp)) q = longint'(zp);
    return q;
  endfunction

  task automatic build_expected();
    logic [DW-1:0] v;
    longint e;
    bit s;
    bit relu_eff;
    int cnt;
    relu_eff = 1'b0;
`ifdef QUANT_RELU_EN
    relu_eff = t_relu;
`endif
    exp_sat = 0;
    for (int b = 0; b < BEATS; b++) begin
      v = '0;
      cnt = 0;
      for (int g = 0; g < G; g++) begin
        for (int c = 0; c < COLS; c++) begin
          e = ref_elem(t_acc[b*G+g][c], t_scale[c], t_shift[c], t_zp, relu_eff, s);
          v[(g*COLS+c)*OW +: OW] = OW'(e);
          if (s) cnt++;
        end
      end
      exp_q.push_back(v);
      row_q.push_back(RW'(b * G));
      exp_sat = (exp_sat + cnt > 65535) ? 65535 : exp_sat + cnt;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic fill(input int a, input int sc, input int sh, input int zp);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) t_acc[r][c] = a;
    for (int c = 0; c < COLS; c++) begin
      t_scale[c] = sc;
      t_shift[c] = sh;
    end
    t_zp = zp;
  endtask

  task automatic fill_random();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        t_acc[r][c] = ($urandom_range(0, 1) == 1) ? int'($urandom)
                                                  : int'($urandom_range(0, 8191)) - 4096;
    for (int c = 0; c < COLS; c++) begin
      t_scale[c] = int'($urandom_range(0, 65535));
      t_shift[c] = int'($urandom_range(0, 63));
    end
    t_zp = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic apply_tile();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) acc_in[r][c] = AW'(t_acc[r][c]);
    for (int c = 0; c < COLS; c++) begin
      scale[c] = SW'(t_scale[c]);
      shift[c] = HW'(t_shift[c]);
    end
    zero_point = OW'(t_zp);
`ifdef QUANT_RELU_EN
    relu_en = t_relu;
`endif
  endtask

  task automatic scramble_inputs();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) acc_in[r][c] = AW'($urandom);
    for (int c = 0; c < COLS; c++) begin
      scale[c] = SW'($urandom);
      shift[c] = HW'($urandom);
    end
    zero_point = OW'($urandom);
`ifdef QUANT_RELU_EN
    relu_en = ~relu_en;
`endif
  endtask

  // Launch a tile: capture edge, then latency checks, then corrupt inputs.
  task automatic launch(input int mode);
    ready_mode = mode;
    build_expected();
    apply_tile();
    hs_count  = 0;
    done_seen = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    scramble_inputs();
    @(negedge clk);
    check("lat_busy", DW'(busy), DW'(1'b1));
    check("lat_pre_valid", DW'(out_valid), DW'(1'b0));
    @(negedge clk);
    check("lat_first_valid", DW'(out_valid), DW'(1'b1));
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done_seen; i++) begin
      @(negedge clk); #1;
    end
    check("done_seen", DW'(done_seen), DW'(1'b1));
  endtask

  task automatic run_tile(input int mode, input bit mid_start);
    launch(mode);
    if (mid_start) begin
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    wait_done(600);
    check("beats_left", DW'(exp_q.size()), DW'(0));
    check("sat_count", DW'(sat_count), DW'(exp_sat));
  endtask

  // Consumer ready pattern: 0 always ready, 1 = 1,0,0 repeating, 2 random.
  initial begin
    int cyc;
    cyc = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  // ---------------- scoreboard / monitor ----------------
  initial begin
    bit            prev_stall;
    bit            prev_done;
    logic [DW-1:0] held_data;
    logic [RW-1:0] held_row;
    logic [DW-1:0] ed;
    logic [RW-1:0] er;
    prev_stall = 1'b0;
    prev_done  = 1'b0;
    held_data  = '0;
    held_row   = '0;
    forever begin
      @(negedge clk);
      if (prev_stall && !reset) begin
        check("hold_valid", DW'(out_valid), DW'(1'b1));
        check("hold_data", out_data, held_data);
        check("hold_row", DW'(out_row), DW'(held_row));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", DW'(exp_q.size()), DW'(1));
        end else begin
          ed = exp_q.pop_front();
          er = row_q.pop_front();
          check("beat_data", out_data, ed);
          check("beat_row", DW'(out_row), DW'(er));
        end
        if (hs_count == 0) first_elem = out_data[0][0];
        hs_count++;
      end
      if (prev_done) begin
        check("done_one_cycle", DW'(done), DW'(1'b0));
        check("busy_after_done", DW'(busy), DW'(1'b0));
      end
      if (done) begin
        done_seen = 1'b1;
        check("done_after_last", DW'(hs_count), DW'(BEATS));
        check("done_busy", DW'(busy), DW'(1'b1));
      end
      prev_done  = done;
      prev_stall = out_valid && !out_ready && !reset;
      held_data  = out_data;
      held_row   = out_row;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    n_checks   = 0;
    n_bad      = 0;
    hs_count   = 0;
    done_seen  = 1'b0;
    ready_mode = 0;
    t_relu     = 1'b0;
    first_elem = '0;
    reset      = 1'b1;
    start      = 1'b0;
    fill(0, 0, 0, 0);
    apply_tile();

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    check("rst_valid", DW'(out_valid), DW'(1'b0));
    check("rst_busy", DW'(busy), DW'(1'b0));
    check("rst_done", DW'(done), DW'(1'b0));
    check("rst_row", DW'(out_row), DW'(0));
    check("rst_sat", DW'(sat_count), DW'(0));
    check("rst_data", out_data, DW'(0));

    // Basic quantization: (500 + 4) >> 3 = 63.
    fill(100, 5, 3, 0);
    run_tile(0, 1'b0);
    check("basic_elem", DW'(first_elem), z8(63));

    // Negative rounding, zero point, and zero shift.
    fill(-100, 5, 3, 0);
    run_tile(2, 1'b0);
    check("neg_elem", DW'(first_elem), z8(-62));
    fill(-100, 5, 3, 10);
    run_tile(2, 1'b0);
    check("neg_zp_elem", DW'(first_elem), z8(-52));
    fill(7, 1, 0, 0);
    run_tile(0, 1'b0);
    check("shift0_elem", DW'(first_elem), z8(7));

    // Saturation in column 0 only.
    fill(0, 3, 4, 0);
    for (int r = 0; r < ROWS; r++) t_acc[r][0] = 1000;
    run_tile(0, 1'b0);
    check("sat_hi_elem", DW'(first_elem), z8(127));
    check("sat_hi_count", DW'(sat_count), DW'(ROWS));
    for (int r = 0; r < ROWS; r++) t_acc[r][0] = -1000;
    run_tile(2, 1'b0);
    check("sat_lo_elem", DW'(first_elem), z8(-128));
    check("sat_lo_count", DW'(sat_count), DW'(ROWS));

    // Back-pressure with a start pulse and input changes mid-drain.
    fill_random();
    run_tile(1, 1'b1);

    // Random tiles under random back-pressure.
    for (int k = 0; k < 4; k++) begin
      fill_random();
      run_tile(2, 1'b0);
    end

    // Reset while beat 3 is presented.
    fill_random();
    launch(0);
    for (int i = 0; i < 50 && hs_count < 3; i++) begin
      @(negedge clk); #1;
    end
    check("reach_beat3", DW'(hs_count), DW'(3));
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("abort_valid", DW'(out_valid), DW'(1'b0));
    check("abort_busy", DW'(busy), DW'(1'b0));
    exp_q.delete();
    row_q.delete();
    done_seen = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    check("abort_no_done", DW'(done_seen), DW'(1'b0));
    check("abort_idle_valid", DW'(out_valid), DW'(1'b0));

    // A fresh tile after the abort drains normally.
    fill_random();
    run_tile(2, 1'b0);

`ifdef QUANT_RELU_EN
    fill(-100, 5, 3, 0);
    t_relu = 1'b1;
    run_tile(0, 1'b0);
    check("relu_on_elem", DW'(first_elem), z8(0));
    check("relu_on_sat", DW'(sat_count), DW'(0));
    t_relu = 1'b0;
    run_tile(0, 1'b0);
    check("relu_off_elem", DW'(first_elem), z8(-62));
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule
